m_load_rx: RTL and testbench

- Memory-stage load return unit: the read-side counterpart of the store byte-enable path.
- Accepts a load from the M stage and checks it for AdEL. Legal loads issue one word-aligned read on the bridge read channel and wait for the response. The addressed byte or halfword is then extracted and sign/zero-extended.
- Returns the result to the W-stage register with a one-cycle valid pulse.
- Holds `busy` so the pipeline stalls while a load is outstanding.

---
 rtl/m_load_rx.sv | 205 ++++++++++++++++++++
 tb/tb_m_load_rx.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_load_rx.sv
// Memory-stage load return unit: checks a load for AdEL, issues one word read on the
// bridge, then returns the extracted, sign/zero-extended result with a one-cycle pulse.
module m_load_rx #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  DEOp,
   input  logic [31:0] Addr,
   input  logic        M_EXC_DMOv,
   input  logic        flush,
   output logic        m_rd_req,
   output logic [31:0] m_rd_addr,
   input  logic        m_rd_ready,
   input  logic        m_rd_rvalid,
   input  logic [31:0] m_rd_rdata,
   output logic        busy,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        M_EXC_AdEL,
   output logic        bus_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LBU = 3'd1;
   localparam logic [2:0] OP_LB  = 3'd2;
   localparam logic [2:0] OP_LHU = 3'd3;
   localparam logic [2:0] OP_LH  = 3'd4;

   // Address windows, index 0 = DM, 1 = TC0, 2 = UART, 3 = DigTube, 4 = LED.
   localparam int N_WIN    = 5;
   localparam int WIN_TC0  = 1;
   localparam int WIN_UART = 2;
   localparam logic [N_WIN*32-1:0] WIN_LO = {32'h0000_7F60, 32'h0000_7F50, 32'h0000_7F30,
                                             32'h0000_7F00, 32'h0000_0000};
   localparam logic [N_WIN*32-1:0] WIN_HI = {32'h0000_7F63, 32'h0000_7F57, 32'h0000_7F3F,
                                             32'h0000_7F0B, 32'h0000_2FFF};

   state_t            r_state, w_state_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   logic [2:0]        r_op;
   logic [1:0]        r_off;
   logic              r_fault;
   logic [31:0]       r_rd_addr;
   logic [31:0]       r_ld_data;
   logic              r_ael;
   logic              r_berr;

   logic [N_WIN-1:0]  w_hit;
   logic [2:0]        w_op;
   logic              w_fault;
   logic              w_accept;
   logic              w_timeout;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_ext;
   logic              w_resp_load;
   logic              w_resp_ael;
   logic              w_resp_berr;
   logic [31:0]       w_resp_data;

   // Unsigned offset compare keeps each window test a single subtract-and-compare.
   genvar gi;
   generate
      for (gi = 0; gi < N_WIN; gi++) begin : g_win
         assign w_hit[gi] = (Addr - WIN_LO[gi*32 +: 32]) <= (WIN_HI[gi*32 +: 32] - WIN_LO[gi*32 +: 32]);
      end
   endgenerate

   assign w_op     = (DEOp > OP_LH) ? OP_LW : DEOp;
   assign w_fault  = M_EXC_DMOv
                   | ~(|w_hit)
                   | ((w_op == OP_LW) & (Addr[1:0] != 2'b00))
                   | (((w_op == OP_LH) | (w_op == OP_LHU)) & Addr[0])
                   | ((w_op != OP_LW) & (w_hit[WIN_TC0] | w_hit[WIN_UART]));
   assign w_accept  = (r_state == S_IDLE) & start & ~flush;
   assign w_timeout = (r_cnt >= CNT_W'(TIMEOUT - 1));

   assign w_byte = m_rd_rdata[{r_off, 3'b000} +: 8];
   assign w_half = r_off[1] ? m_rd_rdata[31:16] : m_rd_rdata[15:0];

   always_comb begin
      w_ext = m_rd_rdata;
      case (r_op)
         OP_LBU:  w_ext = {24'd0, w_byte};
         OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
         OP_LHU:  w_ext = {16'd0, w_half};
         OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
         default: w_ext = m_rd_rdata;
      endcase
   end

   // A faulting load passes through WAIT with r_fault set (no request) so its
   // AdEL pulse lands one cycle after acceptance, never touching the bus.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = '0;
      w_resp_load  = 1'b0;
      w_resp_ael   = 1'b0;
      w_resp_berr  = 1'b0;
      w_resp_data  = '0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_next = w_fault ? S_WAIT : S_REQ;
         end
         S_REQ: begin
            w_cnt_next = r_cnt + CNT_W'(1);
            if (flush) begin
               w_state_next = m_rd_ready ? S_DRAIN : S_IDLE;
               w_cnt_next   = '0;
            end else if (m_rd_ready) begin
               w_state_next = S_WAIT;
               w_cnt_next   = '0;
            end else if (w_timeout) begin
               w_state_next = S_RESP;
               w_resp_load  = 1'b1;
               w_resp_berr  = 1'b1;
            end
         end
         S_WAIT: begin
            w_cnt_next = r_cnt + CNT_W'(1);
            if (r_fault) begin
               if (flush) begin
                  w_state_next = S_IDLE;
               end else begin
                  w_state_next = S_RESP;
                  w_resp_load  = 1'b1;
                  w_resp_ael   = 1'b1;
               end
            end else if (m_rd_rvalid) begin
               if (flush) begin
                  w_state_next = S_IDLE;
               end else begin
                  w_state_next = S_RESP;
                  w_resp_load  = 1'b1;
                  w_resp_data  = w_ext;
               end
            end else if (flush) begin
               w_state_next = S_DRAIN;
            end else if (w_timeout) begin
               w_state_next = S_RESP;
               w_resp_load  = 1'b1;
               w_resp_berr  = 1'b1;
            end
         end
         S_DRAIN: begin
            w_cnt_next = r_cnt + CNT_W'(1);
            if (m_rd_rvalid | w_timeout) w_state_next = S_IDLE;
         end
         S_RESP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_op      <= OP_LW;
         r_off     <= 2'b00;
         r_fault   <= 1'b0;
         r_rd_addr <= '0;
         r_ld_data <= '0;
         r_ael     <= 1'b0;
         r_berr    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_op    <= w_op;
            r_off   <= Addr[1:0];
            r_fault <= w_fault;
            if (!w_fault) r_rd_addr <= {Addr[31:2], 2'b00};
         end
         if (w_resp_load) begin
            r_ld_data <= w_resp_data;
            r_ael     <= w_resp_ael;
            r_berr    <= w_resp_berr;
         end
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign m_rd_req   = (r_state == S_REQ);
   assign ld_valid   = (r_state == S_RESP);
   assign m_rd_addr  = r_rd_addr;
   assign ld_data    = r_ld_data;
   assign M_EXC_AdEL = r_ael;
   assign bus_err    = r_berr;

endmodule

// File: tb/tb_m_load_rx.sv
// Randomized scoreboard bench for m_load_rx: a driver issues loads and models the
// bridge, a separate monitor matches every ld_valid pulse and bus request.
module tb_m_load_rx;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  DEOp = 3'd0;
   logic [31:0] Addr = 32'd0;
   logic        M_EXC_DMOv = 1'b0;
   logic        flush = 1'b0;
   logic        m_rd_ready = 1'b0;
   logic        m_rd_rvalid = 1'b0;
   logic [31:0] m_rd_rdata = 32'd0;
   logic        m_rd_req;
   logic [31:0] m_rd_addr;
   logic        busy;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        M_EXC_AdEL;
   logic        bus_err;

   m_load_rx #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .reset(rst_n), .start(start), .DEOp(DEOp), .Addr(Addr),
      .M_EXC_DMOv(M_EXC_DMOv), .flush(flush), .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr),
      .m_rd_ready(m_rd_ready), .m_rd_rvalid(m_rd_rvalid), .m_rd_rdata(m_rd_rdata),
      .busy(busy), .ld_valid(ld_valid), .ld_data(ld_data), .M_EXC_AdEL(M_EXC_AdEL),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   int checks = 0;
   int failures = 0;
   int ntx = 0;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        ael;
      logic        berr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] addr_q[$];
   exp_t        mon_e;
   logic        prev_lv = 1'b0;

   // DM, TC0, UART, DigTube, LED
   logic [31:0] win_lo [5] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F30, 32'h0000_7F50, 32'h0000_7F60};
   logic [31:0] win_hi [5] = '{32'h0000_2FFF, 32'h0000_7F0B, 32'h0000_7F3F, 32'h0000_7F57, 32'h0000_7F63};

   function automatic void model(input logic [2:0] op_in, input logic [31:0] a, input logic dmov,
                                 input logic [31:0] w, output bit fault, output logic [31:0] res);
      int          op;
      int          size;
      bit          in_win;
      bit          io_win;
      logic [31:0] sh;
      op     = (op_in > 3'd4) ? 0 : int'(op_in);
      size   = (op == 0) ? 4 : ((op <= 2) ? 1 : 2);
      in_win = 1'b0;
      io_win = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (a >= win_lo[k] && a <= win_hi[k]) begin
            in_win = 1'b1;
            if (k == 1 || k == 2) io_win = 1'b1;
         end
      end
      fault = dmov || !in_win || ((int'(a[1:0]) % size) != 0) || (io_win && size != 4);
      sh = w >> (8 * int'(a[1:0]));
      if (size == 4) begin
         res = w;
      end else if (size == 1) begin
         res = sh & 32'h0000_00FF;
         if (op == 2 && res[7]) res = res | 32'hFFFF_FF00;
      end else begin
         res = sh & 32'h0000_FFFF;
         if (op == 4 && res[15]) res = res | 32'hFFFF_0000;
      end
      if (fault) res = 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      end
   endtask

   // Monitor: bus-request address check, result scoreboard, pulse width.
   initial forever begin
      @(negedge clk);
      if (m_rd_req === 1'b1) begin
         checks++;
         if (addr_q.size() == 0) begin
            failures++;
            $display("FAIL rd_req_unexpected cyc=%0d got addr=%h want no request", cyc, m_rd_addr);
         end else if (m_rd_addr !== addr_q[0]) begin
            failures++;
            $display("FAIL rd_addr cyc=%0d got=%h want=%h", cyc, m_rd_addr, addr_q[0]);
         end
      end
      if (prev_lv) begin
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_pulse cyc=%0d got=%b want=0", cyc, busy);
         end
      end
      prev_lv = (ld_valid === 1'b1);
      if (ld_valid === 1'b1) begin
         checks++;
         ntx++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL ld_valid_unexpected cyc=%0d got data=%h ael=%b berr=%b want no pulse",
                     cyc, ld_data, M_EXC_AdEL, bus_err);
         end else begin
            mon_e = exp_q.pop_front();
            if (cyc != mon_e.cyc || ld_data !== mon_e.data || M_EXC_AdEL !== mon_e.ael || bus_err !== mon_e.berr) begin
               failures++;
               $display("FAIL ld_result txn=%0d got cyc=%0d data=%h ael=%b berr=%b want cyc=%0d data=%h ael=%b berr=%b",
                        ntx, cyc, ld_data, M_EXC_AdEL, bus_err, mon_e.cyc, mon_e.data, mon_e.ael, mon_e.berr);
            end else begin
               $display("txn %0d cyc=%0d data=%h ael=%b berr=%b ok", ntx, cyc, ld_data, M_EXC_AdEL, bus_err);
            end
         end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
         checks++;
         failures++;
         $display("FAIL ld_valid_missing cyc=%0d got no pulse want pulse at cyc=%0d", cyc, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
   end

   // While busy, drive junk (start included) to show it is ignored; leave with start low.
   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0) begin
         start      = 1'($urandom_range(0, 1));
         DEOp       = 3'($urandom);
         Addr       = $urandom;
         M_EXC_DMOv = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
         if (n > 40) begin
            checks++;
            failures++;
            $display("FAIL busy_stuck cyc=%0d got busy=1 want 0 within 40 cycles", cyc);
            break;
         end
      end
      start = 1'b0;
   endtask

   // mode 0 normal, 1 flush in WAIT, 2 never ready (timeout), 3 flush with start,
   // 4 flush+ready in REQ, 5 flush in REQ without ready
   task automatic run_load(input logic [2:0] op, input logic [31:0] addr, input logic dmov,
                           input logic [31:0] rdata, input int rdly, input int vdly, input int mode);
      bit          f;
      logic [31:0] d;
      int          t;
      model(op, addr, dmov, rdata, f, d);
      t          = cyc;
      start      = 1'b1;
      DEOp       = op;
      Addr       = addr;
      M_EXC_DMOv = dmov;
      flush      = (mode == 3);
      if (mode == 3) begin
         @(negedge clk);
         start = 1'b0;
         flush = 1'b0;
         chk("flush_over_start", {31'd0, busy}, 32'd0);
         return;
      end
      if (f) begin
         exp_q.push_back('{t + 2, 32'd0, 1'b1, 1'b0});
         @(negedge clk);
         start = 1'b0;
         wait_idle();
         return;
      end
      addr_q.push_back({addr[31:2], 2'b00});
      if (mode == 0) exp_q.push_back('{t + 3 + rdly + vdly, d, 1'b0, 1'b0});
      if (mode == 2) exp_q.push_back('{t + 1 + TIMEOUT, 32'd0, 1'b0, 1'b1});
      @(negedge clk);
      start = 1'b0;
      case (mode)
         0: begin
            repeat (rdly) @(negedge clk);
            m_rd_ready = 1'b1;
            @(negedge clk);
            m_rd_ready = 1'b0;
            void'(addr_q.pop_front());
            repeat (vdly) begin
               m_rd_rdata = $urandom;
               @(negedge clk);
            end
            m_rd_rvalid = 1'b1;
            m_rd_rdata  = rdata;
            @(negedge clk);
            m_rd_rvalid = 1'b0;
            m_rd_rdata  = $urandom;
            wait_idle();
         end
         1: begin
            m_rd_ready = 1'b1;
            @(negedge clk);
            m_rd_ready = 1'b0;
            void'(addr_q.pop_front());
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk("drain_busy1", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("drain_busy2", {31'd0, busy}, 32'd1);
            m_rd_rvalid = 1'b1;
            m_rd_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            m_rd_rvalid = 1'b0;
            chk("drain_release", {31'd0, busy}, 32'd0);
         end
         2: begin
            wait_idle();
            void'(addr_q.pop_front());
         end
         4: begin
            m_rd_ready = 1'b1;
            flush      = 1'b1;
            @(negedge clk);
            m_rd_ready = 1'b0;
            flush      = 1'b0;
            void'(addr_q.pop_front());
            chk("req_flush_drain", {31'd0, busy}, 32'd1);
            m_rd_rvalid = 1'b1;
            m_rd_rdata  = $urandom;
            @(negedge clk);
            m_rd_rvalid = 1'b0;
            chk("req_flush_release", {31'd0, busy}, 32'd0);
         end
         default: begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            void'(addr_q.pop_front());
            chk("req_flush_drop", {31'd0, busy}, 32'd0);
         end
      endcase
   endtask

   task automatic reset_mid_wait();
      start      = 1'b1;
      DEOp       = 3'd0;
      Addr       = 32'h0000_0040;
      M_EXC_DMOv = 1'b0;
      addr_q.push_back(32'h0000_0040);
      @(negedge clk);
      start      = 1'b0;
      m_rd_ready = 1'b1;
      @(negedge clk);
      m_rd_ready = 1'b0;
      void'(addr_q.pop_front());
      chk("in_wait_busy", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ctl", {27'd0, busy, ld_valid, m_rd_req, M_EXC_AdEL, bus_err}, 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_rd_addr", m_rd_addr, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ctl", {27'd0, busy, ld_valid, m_rd_req, M_EXC_AdEL, bus_err}, 32'd0);
      m_rd_rvalid = 1'b1;
      m_rd_rdata  = 32'hCAFE_F00D;
      @(negedge clk);
      m_rd_rvalid = 1'b0;
      chk("late_rvalid_1", {30'd0, ld_valid, busy}, 32'd0);
      @(negedge clk);
      chk("late_rvalid_2", {30'd0, ld_valid, busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      int          sel;
      int          md;
      int          mode;
      repeat (3) @(negedge clk);
      chk("por_ctl", {27'd0, busy, ld_valid, m_rd_req, M_EXC_AdEL, bus_err}, 32'd0);
      chk("por_ld_data", ld_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_load(3'd2, 32'h0000_0003, 1'b0, 32'h80FF_1234, 0, 0, 0);
      run_load(3'd1, 32'h0000_0003, 1'b0, 32'h80FF_1234, 0, 0, 0);
      run_load(3'd3, 32'h0000_0002, 1'b0, 32'h80FF_1234, 0, 0, 0);
      reset_mid_wait();
      run_load(3'd0, 32'h0000_0002, 1'b0, $urandom, 0, 0, 0);
      run_load(3'd4, 32'h0000_7F00, 1'b0, $urandom, 0, 0, 0);
      run_load(3'd0, 32'h0000_0100, 1'b0, 32'h1234_5678, 3, 2, 0);
      run_load(3'd0, 32'h0000_0200, 1'b0, $urandom, 0, 0, 1);
      run_load(3'd0, 32'h0000_0204, 1'b0, 32'h0BAD_F00D, 0, 0, 0);
      run_load(3'd0, 32'h0000_0300, 1'b0, $urandom, 0, 0, 2);
      run_load(3'd0, 32'h0000_7F04, 1'b0, 32'h5555_AAAA, 1, 1, 0);
      run_load(3'd5, 32'h0000_0010, 1'b1, $urandom, 0, 0, 0);
      run_load(3'd2, 32'h0000_0011, 1'b0, $urandom, 0, 0, 3);
      run_load(3'd1, 32'h0000_0012, 1'b0, $urandom, 0, 0, 4);
      run_load(3'd4, 32'h0000_0014, 1'b0, $urandom, 0, 0, 5);

      for (int i = 0; i < 200; i++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 5) begin
            a = 32'($urandom_range(0, 32'h2FFF));
         end else if (sel == 6) begin
            case ($urandom_range(0, 3))
               0:       a = 32'h0000_7F00 + 32'($urandom_range(0, 15));
               1:       a = 32'h0000_7F30 + 32'($urandom_range(0, 15));
               2:       a = 32'h0000_7F50 + 32'($urandom_range(0, 15));
               default: a = 32'h0000_7F60 + 32'($urandom_range(0, 7));
            endcase
         end else if (sel == 7) begin
            a = (i % 2 == 0) ? (32'h0000_3000 + 32'($urandom_range(0, 32'hFFF))) : $urandom;
         end else begin
            a = {20'd0, 10'($urandom_range(0, 32'h2FF)), 2'b00};
         end
         md = $urandom_range(0, 19);
         mode = (md == 0) ? 1 : (md == 1) ? 3 : (md == 2) ? 4 : (md == 3) ? 5 : (md == 4) ? 2 : 0;
         run_load(3'($urandom_range(0, 7)), a, 1'($urandom_range(0, 15) == 0), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), mode);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
